// File: rtl/ysyx_25030077_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, access size codes
// and the alignment rule used to reject accesses before they reach the bus.
package ysyx_25030077_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } lsu_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam int         ZEXT_BIT = 2;

  // Size code 3 is treated as illegal alongside the misaligned cases.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25030077_lsu_ext.sv
// Load data extension: byte/half are sign- or zero-extended from the low bits
// according to the access mask; words pass through.
module ysyx_25030077_lsu_ext
  import ysyx_25030077_lsu_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [2:0]  mask,
  output logic [31:0] data_out
);

  logic fill_byte;
  logic fill_half;

  assign fill_byte = data_in[7]  & ~mask[ZEXT_BIT];
  assign fill_half = data_in[15] & ~mask[ZEXT_BIT];

  always_comb begin
    data_out = data_in;
    case (mask[1:0])
      SZ_BYTE: data_out = {{24{fill_byte}}, data_in[7:0]};
      SZ_HALF: data_out = {{16{fill_half}}, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/ysyx_25030077_lsu.sv
// Single-outstanding load/store unit bridging a request/response port to split
// read/write memory channels, with a per-state wait timeout.
module ysyx_25030077_lsu
  import ysyx_25030077_lsu_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic        io_req_wen,
  input  logic [31:0] io_req_addr,
  input  logic [31:0] io_req_wdata,
  input  logic [2:0]  io_req_mask,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [31:0] io_resp_rdata,
  output logic        io_resp_err,
  output logic        io_ar_valid,
  input  logic        io_ar_ready,
  output logic [31:0] io_raddr,
  output logic [2:0]  io_r_mask,
  output logic        io_r_valid,
  output logic        io_aw_valid,
  input  logic        io_aw_ready,
  output logic [31:0] io_waddr,
  output logic        io_w_valid,
  input  logic        io_w_ready,
  output logic [31:0] io_wdata,
  output logic [2:0]  io_w_mask,
  input  logic        io_r__valid,
  output logic        io_r__ready,
  input  logic [31:0] io_mem_data,
  input  logic        io_b_valid,
  output logic        io_b_ready
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  mask_q, mask_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        err_q, err_d;
  logic [31:0] ext_data;
  logic        aw_done_now, w_done_now, timed_out, waiting;

  ysyx_25030077_lsu_ext u_ext (
    .data_in  (io_mem_data),
    .mask     (mask_q),
    .data_out (ext_data)
  );

  // Ready is withheld while reset is held even though the state already reads IDLE.
  assign io_req_ready  = (state_q == S_IDLE) & ~reset;
  assign io_resp_valid = (state_q == S_RESP);
  assign io_resp_rdata = rdata_q;
  assign io_resp_err   = err_q;
  assign io_ar_valid   = (state_q == S_AR);
  assign io_r_valid    = (state_q == S_AR);
  assign io_raddr      = addr_q;
  assign io_r_mask     = mask_q;
  assign io_aw_valid   = (state_q == S_AW_W) & ~aw_done_q;
  assign io_w_valid    = (state_q == S_AW_W) & ~w_done_q;
  assign io_waddr      = addr_q;
  assign io_wdata      = wdata_q;
  assign io_w_mask     = mask_q;
  assign io_r__ready   = (state_q == S_R) | (state_q == S_B);
  assign io_b_ready    = (state_q == S_R) | (state_q == S_B);

  assign aw_done_now = aw_done_q | io_aw_ready;
  assign w_done_now  = w_done_q | io_w_ready;
  assign timed_out   = (cnt_q == TIMEOUT);
  assign waiting     = (state_q == S_AR) | (state_q == S_R) |
                       (state_q == S_AW_W) | (state_q == S_B);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mask_d    = mask_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (io_req_valid) begin
          addr_d  = io_req_addr;
          wdata_d = io_req_wdata;
          mask_d  = io_req_mask;
          rdata_d = 32'd0;
          err_d   = 1'b0;
          if (access_bad(io_req_mask[1:0], io_req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (io_req_wen) begin
            state_d = S_AW_W;
          end else begin
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        if (io_ar_ready) begin
          state_d = S_R;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_R: begin
        // A response on the timeout cycle still wins.
        if (io_r__valid) begin
          rdata_d = ext_data;
          state_d = S_RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_AW_W: begin
        aw_done_d = aw_done_now;
        w_done_d  = w_done_now;
        if (aw_done_now && w_done_now) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_B;
        end else if (timed_out) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_B: begin
        if (io_b_valid) begin
          state_d = S_RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (io_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d != state_q || !waiting) ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      mask_q    <= 3'd0;
      cnt_q     <= 8'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25030077_lsu.sv
// Randomized and directed checks of the LSU against a cycle-window reference
// model derived from access legality, memory delays and the timeout limit.
module tb_ysyx_25030077_lsu;

  localparam logic [7:0] TO = 8'd4;

  logic        clock, reset;
  logic        io_req_valid, io_req_ready, io_req_wen;
  logic [31:0] io_req_addr, io_req_wdata;
  logic [2:0]  io_req_mask;
  logic        io_resp_valid, io_resp_ready, io_resp_err;
  logic [31:0] io_resp_rdata;
  logic        io_ar_valid, io_ar_ready, io_r_valid;
  logic [31:0] io_raddr;
  logic [2:0]  io_r_mask;
  logic        io_aw_valid, io_aw_ready;
  logic [31:0] io_waddr;
  logic        io_w_valid, io_w_ready;
  logic [31:0] io_wdata;
  logic [2:0]  io_w_mask;
  logic        io_r__valid, io_r__ready;
  logic [31:0] io_mem_data;
  logic        io_b_valid, io_b_ready;

  int n_cmp = 0;
  int n_bad = 0;

  ysyx_25030077_lsu #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready), .io_req_wen(io_req_wen),
    .io_req_addr(io_req_addr), .io_req_wdata(io_req_wdata), .io_req_mask(io_req_mask),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_rdata(io_resp_rdata), .io_resp_err(io_resp_err),
    .io_ar_valid(io_ar_valid), .io_ar_ready(io_ar_ready), .io_raddr(io_raddr),
    .io_r_mask(io_r_mask), .io_r_valid(io_r_valid),
    .io_aw_valid(io_aw_valid), .io_aw_ready(io_aw_ready), .io_waddr(io_waddr),
    .io_w_valid(io_w_valid), .io_w_ready(io_w_ready), .io_wdata(io_wdata), .io_w_mask(io_w_mask),
    .io_r__valid(io_r__valid), .io_r__ready(io_r__ready), .io_mem_data(io_mem_data),
    .io_b_valid(io_b_valid), .io_b_ready(io_b_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] d, input logic [2:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (m[1:0])
      2'd0:    return m[2] ? 32'(b) : 32'($signed(b));
      2'd1:    return m[2] ? 32'(h) : 32'($signed(h));
      default: return d;
    endcase
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // k counts falling edges after the accepting rising edge. d1/d2/d3 are the
  // cycle offsets at which memory answers within each wait phase.
  task automatic do_txn(input string tag, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] mask,
                        input int d1, input int d2, input int d3,
                        input logic [31:0] mdata, input int hold);
    int T = int'(TO);
    bit bad;
    int ar_hi = 0, r_lo = 1, r_hi = 0, aw_hi = 0, w_hi = 0, b_lo = 1, b_hi = 0;
    int resp_k, m, t_ar, t_r, t_aw, t_w, t_b;
    bit exp_err = 1'b0;
    logic [31:0] exp_rd = 32'd0;
    bit in_rb;

    bad = (mask[1:0] == 2'd3) || (mask[1:0] == 2'd1 && addr[0]) ||
          (mask[1:0] == 2'd2 && addr[1:0] != 2'd0);
    m = imax(d1, d2);
    t_ar = -1; t_r = -1; t_aw = -1; t_w = -1; t_b = -1;
    if (bad) begin
      resp_k = 1;
      exp_err = 1'b1;
    end else if (!wen) begin
      ar_hi = 1 + imin(d1, T);
      t_ar = 1 + d1;
      if (d1 > T) begin
        resp_k = ar_hi + 1;
        exp_err = 1'b1;
      end else begin
        r_lo = ar_hi + 1;
        r_hi = r_lo + imin(d2, T);
        t_r = r_lo + d2;
        resp_k = r_hi + 1;
        exp_err = (d2 > T);
        if (!exp_err) exp_rd = ext_model(mdata, mask);
      end
    end else begin
      aw_hi = 1 + imin(d1, T);
      w_hi = 1 + imin(d2, T);
      t_aw = 1 + d1;
      t_w = 1 + d2;
      if (m > T) begin
        resp_k = 2 + T;
        exp_err = 1'b1;
      end else begin
        b_lo = 2 + m;
        b_hi = b_lo + imin(d3, T);
        t_b = b_lo + d3;
        resp_k = b_hi + 1;
        exp_err = (d3 > T);
      end
    end

    @(negedge clock);
    io_req_valid = 1'b1;
    io_req_wen = wen;
    io_req_addr = addr;
    io_req_wdata = wdata;
    io_req_mask = mask;
    io_resp_ready = 1'b0;
    chk_eq({tag, ".req_ready"}, io_req_ready, 1'b1);

    for (int k = 1; k <= resp_k; k++) begin
      @(negedge clock);
      in_rb = (k >= r_lo && k <= r_hi) || (k >= b_lo && k <= b_hi);
      chk_eq({tag, ".ar_valid"}, io_ar_valid, (k <= ar_hi));
      chk_eq({tag, ".r_valid"}, io_r_valid, (k <= ar_hi));
      chk_eq({tag, ".aw_valid"}, io_aw_valid, (k <= aw_hi));
      chk_eq({tag, ".w_valid"}, io_w_valid, (k <= w_hi));
      chk_eq({tag, ".r__ready"}, io_r__ready, in_rb);
      chk_eq({tag, ".b_ready"}, io_b_ready, in_rb);
      chk_eq({tag, ".resp_valid"}, io_resp_valid, (k == resp_k));
      chk_eq({tag, ".req_ready_busy"}, io_req_ready, 1'b0);
      if (k <= ar_hi) begin
        chk_eq({tag, ".raddr"}, io_raddr, addr);
        chk_eq({tag, ".r_mask"}, io_r_mask, mask);
      end
      if (k <= aw_hi) chk_eq({tag, ".waddr"}, io_waddr, addr);
      if (k <= w_hi) begin
        chk_eq({tag, ".wdata"}, io_wdata, wdata);
        chk_eq({tag, ".w_mask"}, io_w_mask, mask);
      end
      // Unrelated request traffic while busy must be ignored.
      io_req_valid = 1'($urandom_range(0, 1));
      io_req_wen = 1'($urandom_range(0, 1));
      io_req_addr = $urandom;
      io_req_mask = 3'($urandom_range(0, 7));
      io_ar_ready = (k == t_ar);
      io_r__valid = (k == t_r);
      io_mem_data = (k == t_r) ? mdata : $urandom;
      io_aw_ready = (k == t_aw);
      io_w_ready = (k == t_w);
      io_b_valid = (k == t_b);
    end
    chk_eq({tag, ".rdata"}, io_resp_rdata, exp_rd);
    chk_eq({tag, ".err"}, io_resp_err, exp_err);

    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      io_ar_ready = 1'b0; io_r__valid = 1'b0; io_aw_ready = 1'b0;
      io_w_ready = 1'b0; io_b_valid = 1'b0;
      chk_eq({tag, ".hold_valid"}, io_resp_valid, 1'b1);
      chk_eq({tag, ".hold_rdata"}, io_resp_rdata, exp_rd);
      chk_eq({tag, ".hold_err"}, io_resp_err, exp_err);
    end
    io_resp_ready = 1'b1;
    io_req_valid = 1'b0;
    io_ar_ready = 1'b0; io_r__valid = 1'b0; io_aw_ready = 1'b0;
    io_w_ready = 1'b0; io_b_valid = 1'b0;
    @(negedge clock);
    io_resp_ready = 1'b0;
    chk_eq({tag, ".done_resp_valid"}, io_resp_valid, 1'b0);
    chk_eq({tag, ".idle_req_ready"}, io_req_ready, 1'b1);
    $display("txn %s wen=%0d addr=%08h mask=%0d d=%0d/%0d/%0d exp_rdata=%08h exp_err=%0d",
             tag, wen, addr, mask, d1, d2, d3, exp_rd, exp_err);
  endtask

  initial begin
    reset = 1'b1;
    io_req_valid = 1'b0; io_req_wen = 1'b0; io_req_addr = 32'd0;
    io_req_wdata = 32'd0; io_req_mask = 3'd0; io_resp_ready = 1'b0;
    io_ar_ready = 1'b0; io_aw_ready = 1'b0; io_w_ready = 1'b0;
    io_r__valid = 1'b0; io_mem_data = 32'd0; io_b_valid = 1'b0;

    #1;
    chk_eq("rst.req_ready", io_req_ready, 1'b0);
    chk_eq("rst.resp_valid", io_resp_valid, 1'b0);
    chk_eq("rst.ar_valid", io_ar_valid, 1'b0);
    chk_eq("rst.aw_valid", io_aw_valid, 1'b0);
    chk_eq("rst.w_valid", io_w_valid, 1'b0);
    chk_eq("rst.r__ready", io_r__ready, 1'b0);
    chk_eq("rst.b_ready", io_b_ready, 1'b0);
    chk_eq("rst.raddr", io_raddr, 32'd0);
    chk_eq("rst.rdata", io_resp_rdata, 32'd0);
    chk_eq("rst.err", io_resp_err, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk_eq("rst.release_ready", io_req_ready, 1'b1);

    do_txn("ldw_basic", 1'b0, 32'h80000004, 32'd0, 3'b010, 3, 2, 0, 32'hDEADBEEF, 1);
    do_txn("ldb_sext", 1'b0, 32'h80000003, 32'd0, 3'b000, 0, 1, 0, 32'h00000080, 0);
    do_txn("ldb_zext", 1'b0, 32'h80000003, 32'd0, 3'b100, 1, 0, 0, 32'h00000080, 0);
    do_txn("ldh_sext", 1'b0, 32'h80000002, 32'd0, 3'b001, 0, 0, 0, 32'h00008001, 2);
    do_txn("ldh_zext", 1'b0, 32'h80000002, 32'd0, 3'b101, 2, 2, 0, 32'h12348001, 0);
    do_txn("stw_split", 1'b1, 32'h80000008, 32'hCAFEF00D, 3'b010, 1, 4, 1, 32'd0, 1);
    do_txn("ldh_misal", 1'b0, 32'h80000001, 32'd0, 3'b001, 0, 0, 0, 32'd0, 0);
    do_txn("stw_misal", 1'b1, 32'h80000006, 32'h1, 3'b010, 0, 0, 0, 32'd0, 0);
    do_txn("ld_size3", 1'b0, 32'h80000000, 32'd0, 3'b011, 0, 0, 0, 32'd0, 0);
    do_txn("ar_timeout", 1'b0, 32'h80000000, 32'd0, 3'b010, 9, 0, 0, 32'd0, 1);
    do_txn("ar_edge_ok", 1'b0, 32'h80000000, 32'd0, 3'b010, 4, 4, 0, 32'h55AA55AA, 0);
    do_txn("r_timeout", 1'b0, 32'h80000000, 32'd0, 3'b010, 0, 7, 0, 32'h1, 0);
    do_txn("aw_timeout", 1'b1, 32'h80000000, 32'h2, 3'b010, 6, 0, 0, 32'd0, 0);
    do_txn("b_timeout", 1'b1, 32'h80000000, 32'h3, 3'b000, 0, 0, 8, 32'd0, 0);

    // Reset while a read response is being offered: abandoned, no response.
    @(negedge clock);
    io_req_valid = 1'b1; io_req_wen = 1'b0;
    io_req_addr = 32'h80000010; io_req_mask = 3'b010;
    @(negedge clock);
    io_req_valid = 1'b0;
    io_ar_ready = 1'b1;
    @(negedge clock);
    io_ar_ready = 1'b0;
    chk_eq("midrst.in_r", io_r__ready, 1'b1);
    io_r__valid = 1'b1; io_mem_data = 32'h0BADF00D;
    #2 reset = 1'b1;
    #1;
    chk_eq("midrst.r__ready", io_r__ready, 1'b0);
    chk_eq("midrst.b_ready", io_b_ready, 1'b0);
    chk_eq("midrst.req_ready", io_req_ready, 1'b0);
    chk_eq("midrst.resp_valid", io_resp_valid, 1'b0);
    chk_eq("midrst.raddr", io_raddr, 32'd0);
    @(posedge clock);
    #1;
    chk_eq("midrst.resp_valid2", io_resp_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    io_r__valid = 1'b0;
    #1;
    chk_eq("midrst.release_ready", io_req_ready, 1'b1);
    @(negedge clock);
    chk_eq("midrst.no_resp", io_resp_valid, 1'b0);
    do_txn("post_rst", 1'b0, 32'h80000010, 32'd0, 3'b010, 1, 1, 0, 32'h13579BDF, 0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      do_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
             3'($urandom_range(0, 7)), $urandom_range(0, 5), $urandom_range(0, 5),
             $urandom_range(0, 5), $urandom, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_25030077_lsu.md
YSYX_25030077_LSU -- requirements
Module: ysyx_25030077_lsu

Interface
REQ-001 Parameter TIMEOUT, 8'd255, max cycles waited in any bus-wait state before error completion.
REQ-002 clock  in  1  single clock; all state on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 io_req_valid/io_req_ready  in/out  1/1  upstream request handshake.
REQ-005 io_req_wen  in  1  1=store, 0=load.
REQ-006 io_req_addr, io_req_wdata  in  32 each  byte address, store data (low-aligned).
REQ-007 io_req_mask  in  3  [1:0] size (0=byte,1=half,2=word,3=illegal); [2] 1=zero-extend load.
REQ-008 io_resp_valid/io_resp_ready  out/in  1/1  completion handshake.
REQ-009 io_resp_rdata  out  32  extended load data; 0 for stores.
REQ-010 io_resp_err  out  1  misaligned, illegal-size or timeout completion.
REQ-011 io_ar_valid out 1, io_ar_ready in 1, io_raddr out 32, io_r_mask out 3, io_r_valid out 1: memory read address channel; io_r_valid is the read qualifier.
REQ-012 io_aw_valid out 1, io_aw_ready in 1, io_waddr out 32: write address channel.
REQ-013 io_w_valid out 1, io_w_ready in 1, io_wdata out 32, io_w_mask out 3: write data channel.
REQ-014 io_r__valid in 1, io_r__ready out 1, io_mem_data in 32: read data channel.
REQ-015 io_b_valid in 1, io_b_ready out 1: write response channel.

Function
REQ-016 FSM states IDLE, AR, R, AW_W, B, RESP; all outputs driven from registers or decoded from state only.
REQ-017 io_req_ready high only in IDLE; accept when io_req_valid & io_req_ready; latch addr, wdata, mask, wen.
REQ-018 Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size 3: IDLE->RESP directly, err=1, rdata=0, no bus activity.
REQ-019 Legal load: IDLE->AR; io_ar_valid=io_r_valid=1, raddr/r_mask stable until io_ar_ready sampled high, then ->R.
REQ-020 Legal store: IDLE->AW_W; io_aw_valid and io_w_valid each held until its own ready seen; per-channel done flags; both done (same or different cycles) ->B.
REQ-021 In R and B, both io_r__ready and io_b_ready SHALL be 1 (memory releases response only when both high).
REQ-022 R: on io_r__valid, capture io_mem_data; size byte/half sign-extend bit 7/15 unless mask[2]=1 (zero-extend); word unchanged; ->RESP.
REQ-023 B: on io_b_valid ->RESP, rdata=0, err=0.
REQ-024 Latency: first bus valid asserted cycle after request accept; io_resp_valid asserted cycle after response handshake.
REQ-025 RESP: io_resp_valid held with stable rdata/err until io_resp_ready; then ->IDLE; next request acceptable in that following cycle.
REQ-026 8-bit wait counter cleared on every state change, increments each cycle in AR, AW_W, R, B; reaching TIMEOUT ->RESP with err=1, all bus valids/readies dropped.
REQ-027 Response arriving in the same cycle the counter reaches TIMEOUT is taken as success.
REQ-028 Request input ignored outside IDLE; no queuing, one outstanding transaction.

Reset
REQ-029 reset asserted at any time (including mid-transaction) forces IDLE asynchronously; all valid/ready outputs 0 except none, io_req_ready 0 during reset and 1 in first cycle after release; addresses, data, masks, rdata, err, counter, done flags 0.
REQ-030 Transaction in flight at reset is abandoned; no response issued.

Structure
REQ-031 Shared package holds FSM state encoding, size codes (BYTE/HALF/WORD) and the zero-extend bit index.
REQ-032 One natural sub-module: ysyx_25030077_lsu_ext (combinational load extension by mask); everything else inline.

Verification
REQ-033 Load word addr 0x80000004, ar_ready after 3 cycles, r__valid after 2 more with 0xDEADBEEF -> resp rdata 0xDEADBEEF, err 0; ar_valid stable throughout.
REQ-034 Load byte signed, mem_data 0x00000080 -> rdata 0xFFFFFF80; same with mask 3'b100 -> 0x00000080; half 0x00008001 signed -> 0xFFFF8001.
REQ-035 Store word, aw_ready at cycle 1, w_ready at cycle 4 -> aw_valid drops after cycle 1, w_valid held to cycle 4, b_ready/r__ready high in B, resp err 0.
REQ-036 Load half addr 0x80000001 -> resp next cycle err 1, no ar_valid ever asserted.
REQ-037 TIMEOUT=4, ar_ready never asserted -> resp err 1 exactly 5 cycles after entering AR; IDLE after resp_ready.
REQ-038 Reset asserted while in R with r__valid pending -> outputs 0 immediately, no resp_valid; new load after release completes normally.
